// File: rtl/prbs31_bert_ctrl.sv
// PRBS31 (x^31 + x^28 + 1) bit-error-rate test controller: seeds the generator and
// runs a self-synchronising checker through fill, sync and a fixed measurement window.
module prbs31_bert_ctrl #(
  parameter int unsigned WIN_LOG2 = 16,
  parameter int unsigned ERR_W    = 16,
  parameter int unsigned SYNC_LEN = 64,
  parameter int unsigned SYNC_TO  = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             loop_sel,
  input  logic             inject_err,
  input  logic             rx_bit,
  output logic             tx_bit,
  output logic             busy,
  output logic             locked,
  output logic             done,
  output logic             sync_fail,
  output logic             sat,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned TO_W = $clog2(SYNC_TO + 1);
  localparam logic [WIN_LOG2:0] WIN_N   = {1'b1, {WIN_LOG2{1'b0}}};
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(SYNC_TO);
  localparam logic [7:0]        RUN_END = 8'(SYNC_LEN);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEED    = 3'd1;
  localparam logic [2:0] S_SYNC    = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [30:0]       gen_q, gen_d;
  logic [30:0]       chk_q, chk_d;
  logic [4:0]        fill_q, fill_d;
  logic [7:0]        run_q, run_d;
  logic [WIN_LOG2:0] win_q, win_d;
  logic [TO_W-1:0]   cyc_q, cyc_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              sat_q, sat_d;
  logic              sync_fail_q, sync_fail_d;
  logic              busy_q, busy_d;
  logic              locked_q, locked_d;
  logic              done_q, done_d;

  logic        tx;
  logic        rx;
  logic        exp_bit;
  logic [30:0] gen_adv;

  always_comb begin
    state_d     = state_q;
    gen_d       = gen_q;
    chk_d       = chk_q;
    fill_d      = fill_q;
    run_d       = run_q;
    win_d       = win_q;
    cyc_d       = cyc_q;
    err_d       = err_q;
    sat_d       = sat_q;
    sync_fail_d = sync_fail_q;

    tx      = gen_q[30] ^ (inject_err & (state_q == S_MEASURE));
    rx      = loop_sel ? rx_bit : tx;
    exp_bit = chk_q[27] ^ chk_q[30];
    gen_adv = {gen_q[29:0], gen_q[27] ^ gen_q[30]};

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) state_d = S_SEED;
        S_SEED: begin
          gen_d       = 31'd1;
          chk_d       = '0;
          fill_d      = '0;
          run_d       = '0;
          win_d       = '0;
          cyc_d       = '0;
          err_d       = '0;
          sat_d       = 1'b0;
          sync_fail_d = 1'b0;
          state_d     = S_SYNC;
        end
        S_SYNC: begin
          gen_d = gen_adv;
          chk_d = {chk_q[29:0], rx};
          cyc_d = cyc_q + 1'b1;
          // Compare only once the shift register holds 31 received bits.
          if (fill_q != 5'd31) fill_d = fill_q + 5'd1;
          else if ((rx == exp_bit) && (chk_q != '0)) run_d = run_q + 8'd1;
          else run_d = '0;
          if (run_d == RUN_END) begin
            state_d = S_MEASURE;
          end else if (cyc_d == TO_LAST) begin
            state_d     = S_DONE;
            sync_fail_d = 1'b1;
            err_d       = '0;
          end
        end
        S_MEASURE: begin
          gen_d = gen_adv;
          // Free-running: feeding back exp keeps one flipped bit from counting three times.
          chk_d = {chk_q[29:0], exp_bit};
          win_d = win_q + 1'b1;
          if ((rx != exp_bit) && (err_q != '1)) err_d = err_q + 1'b1;
          sat_d = sat_q | (&err_d);
          if (win_d == WIN_N) state_d = S_DONE;
        end
        S_DONE: if (start) state_d = S_SEED;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d   = (state_d == S_SEED) || (state_d == S_SYNC) || (state_d == S_MEASURE);
    locked_d = (state_d == S_MEASURE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gen_q       <= 31'd1;
      chk_q       <= '0;
      fill_q      <= '0;
      run_q       <= '0;
      win_q       <= '0;
      cyc_q       <= '0;
      err_q       <= '0;
      sat_q       <= 1'b0;
      sync_fail_q <= 1'b0;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gen_q       <= gen_d;
      chk_q       <= chk_d;
      fill_q      <= fill_d;
      run_q       <= run_d;
      win_q       <= win_d;
      cyc_q       <= cyc_d;
      err_q       <= err_d;
      sat_q       <= sat_d;
      sync_fail_q <= sync_fail_d;
      busy_q      <= busy_d;
      locked_q    <= locked_d;
      done_q      <= done_d;
    end
  end

  assign tx_bit    = tx;
  assign busy      = busy_q;
  assign locked    = locked_q;
  assign done      = done_q;
  assign sync_fail = sync_fail_q;
  assign sat       = sat_q;
  assign err_cnt   = err_q;

endmodule
